// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and constants for the decoder scan sequencer slice.
package decoder_scan_sequencer_pkg;

    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } scan_state_t;

endpackage

// File: rtl/decoder_scan_sequencer_picker.sv
// Circular priority search: next set mask bit strictly after cur, wrapping 3->0.
module slot_next_picker
    import decoder_scan_sequencer_pkg::*;
(
    input  logic [SLOT_W-1:0]    cur,
    input  logic [NUM_SLOTS-1:0] mask,
    output logic [SLOT_W-1:0]    nxt,
    output logic                 wrap,
    output logic                 none
);

    logic [SLOT_W-1:0] idx;
    logic              found;

    always_comb begin
        nxt   = cur;
        wrap  = 1'b0;
        none  = (mask == '0);
        found = 1'b0;
        idx   = '0;
        // k = NUM_SLOTS lands back on cur, so a single-bit mask reselects itself as a wrap
        for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
            idx = cur + SLOT_W'(k);
            if (!found && mask[idx]) begin
                found = 1'b1;
                nxt   = idx;
                wrap  = (idx <= cur);
            end
        end
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a 2-to-4 decoder address through enabled slots with a dwell per slot and
// an enable-low blanking gap before each dwell.
module decoder_scan_sequencer
    import decoder_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_W      = 8,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         slot_mask,
    output logic               address0,
    output logic               address1,
    output logic               enable,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD =
        BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t        state;
    logic [SLOT_W-1:0]  slot;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt;
    logic [DWELL_W-1:0] dwell_in;
    logic [BLANK_W-1:0] bcnt;
    logic               stop_q;
    logic               stop_pending;
    logic [SLOT_W-1:0]  pick_cur;
    logic [SLOT_W-1:0]  pick_nxt;
    logic               pick_wrap;
    logic               pick_none;

    assign dwell_in     = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign stop_pending = stop_q | stop;
    // Searching from the top slot while idle yields the lowest set mask bit.
    assign pick_cur     = (state == IDLE) ? SLOT_W'(NUM_SLOTS - 1) : slot;
    assign address0     = slot[0];
    assign address1     = slot[1];

    slot_next_picker u_picker (
        .cur  (pick_cur),
        .mask (slot_mask),
        .nxt  (pick_nxt),
        .wrap (pick_wrap),
        .none (pick_none)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot       <= '0;
            dwell_q    <= '0;
            dcnt       <= '0;
            bcnt       <= '0;
            stop_q     <= 1'b0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    stop_q <= 1'b0;
                    if (start && !stop && !pick_none) begin
                        slot    <= pick_nxt;
                        dwell_q <= dwell_in;
                        busy    <= 1'b1;
                        if (BLANK_CYCLES == 0) begin
                            state  <= DWELL;
                            enable <= 1'b1;
                            dcnt   <= dwell_in - DWELL_W'(1);
                        end else begin
                            state <= BLANK;
                            bcnt  <= BLANK_LOAD;
                        end
                    end
                end
                BLANK: begin
                    stop_q <= stop_pending;
                    if (bcnt == '0) begin
                        state  <= DWELL;
                        enable <= 1'b1;
                        dcnt   <= dwell_q - DWELL_W'(1);
                    end else begin
                        bcnt <= bcnt - BLANK_W'(1);
                    end
                end
                DWELL: begin
                    if (dcnt != '0) begin
                        dcnt   <= dcnt - DWELL_W'(1);
                        stop_q <= stop_pending;
                    end else if (stop_pending || pick_none) begin
                        state  <= IDLE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        stop_q <= 1'b0;
                    end else begin
                        slot       <= pick_nxt;
                        frame_done <= pick_wrap;
                        if (BLANK_CYCLES == 0) begin
                            dcnt <= dwell_q - DWELL_W'(1);
                        end else begin
                            state  <= BLANK;
                            enable <= 1'b0;
                            bcnt   <= BLANK_LOAD;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
